// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: FSM state encoding and default clocking.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling after a 2-FF synchronizer, framing check on stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_line,
    output logic [7:0]  rx_data,
    output logic        rx_done,
    output uart_state_t state,
    output logic [2:0]  bit_index
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + HALF);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT + HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    uart_state_t      state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [2:0]       bit_index_next;
    logic             rx_sync_p0, rx_sync_p1;
    logic [7:0]       shift;
    logic             stop_bit;
    logic             sample_en, stop_en, done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            bit_index  <= '0;
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_data    <= 8'h00;
            rx_done    <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            bit_index  <= bit_index_next;
            rx_sync_p0 <= rx_line;
            rx_sync_p1 <= rx_sync_p0;
            rx_done    <= done_next;
            if (done_next)
                rx_data <= shift;
        end
    end

    always_ff @(posedge clk) begin
        if (sample_en)
            shift[bit_index] <= rx_sync_p1;
        if (stop_en)
            stop_bit <= rx_sync_p1;
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        bit_index_next = bit_index;
        sample_en      = 1'b0;
        stop_en        = 1'b0;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                count_next     = '0;
                bit_index_next = '0;
                if (!rx_sync_p1)
                    state_next = START;
            end
            START: begin
                if (count == HALF_LAST) begin
                    count_next = '0;
                    state_next = rx_sync_p1 ? IDLE : DATA;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            DATA: begin
                if (count == BIT_LAST) begin
                    count_next = '0;
                    sample_en  = 1'b1;
                    if (bit_index == 3'd7)
                        state_next = STOP;
                    else
                        bit_index_next = bit_index + 3'd1;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            STOP: begin
                // Sample at mid stop bit, but only report once the stop bit has ended.
                if (count == BIT_LAST)
                    stop_en = 1'b1;
                if (count == STOP_LAST) begin
                    count_next = '0;
                    done_next  = stop_bit;
                    state_next = CLEANUP;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            CLEANUP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: latches a byte on request and shifts it out LSB first.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_line
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    uart_state_t      state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [2:0]       bit_index, bit_index_next;
    logic [7:0]       data_reg;
    logic             line_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            bit_index <= '0;
            tx_line   <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            bit_index <= bit_index_next;
            tx_line   <= line_next;
            tx_done   <= (state_next == CLEANUP);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && tx_start)
            data_reg <= tx_data;
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        bit_index_next = bit_index;
        case (state)
            IDLE: begin
                count_next     = '0;
                bit_index_next = '0;
                if (tx_start)
                    state_next = START;
            end
            START: begin
                if (count == BIT_LAST) begin
                    count_next = '0;
                    state_next = DATA;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            DATA: begin
                if (count == BIT_LAST) begin
                    count_next = '0;
                    if (bit_index == 3'd7)
                        state_next = STOP;
                    else
                        bit_index_next = bit_index + 3'd1;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            STOP: begin
                if (count == BIT_LAST) begin
                    count_next = '0;
                    state_next = CLEANUP;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            CLEANUP: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The line is registered from the next state so the pin never glitches.
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = data_reg[bit_index_next];
            default: line_next = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: independent transmitter and receiver on one clock.
module uart_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_line,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    uart_state_t rx_state;
    logic [2:0]  rx_bit_index;

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) tx_inst (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .tx_line  (tx_line)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) rx_inst (
        .clk       (clk),
        .reset     (reset),
        .rx_line   (rx_line),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .state     (rx_state),
        .bit_index (rx_bit_index)
    );

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: loopback vectors plus glitch, framing and reset sequences.
module tb_uart_top;
    import uart_pkg::*;

    localparam int N = 434;

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;
        logic [7:0] exp_rx;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_line;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       loop_en;
    logic       rx_drv;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_seen[$];
    vec_t vecs[4];

    always #10 clk = ~clk;

    assign rx_line = loop_en ? tx_line : rx_drv;

    uart_top dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .tx_line  (tx_line),
        .rx_line  (rx_line),
        .rx_data  (rx_data),
        .rx_done  (rx_done)
    );

    always @(negedge clk) begin
        if (rx_done === 1'b1)
            rx_seen.push_back(rx_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts in the first cycle of the start bit, ends in the cycle after the stop bit.
    task automatic check_bits(input logic [9:0] frame, input string name);
        int bad;
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            repeat (N) begin
                if (tx_line !== frame[k] || tx_done !== 1'b0)
                    bad++;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", name, k), bad, 0);
        end
    endtask

    task automatic send_and_check(input vec_t v, input string name);
        int base;
        int lat;
        base = rx_seen.size();
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = v.din;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~v.din;
        check_bits(v.frame, name);
        check({name, "_tx_done"}, {tx_done, tx_line}, 2'b11);
        lat = 0;
        while (rx_done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_rx_latency_ok"}, (lat >= 1 && lat <= 4), 1);
        check({name, "_rx_data"}, rx_data, v.exp_rx);
        repeat (10) @(negedge clk);
        check({name, "_rx_done_count"}, rx_seen.size() - base, 1);
    endtask

    task automatic drive_rx_frame(input logic [9:0] frame);
        for (int k = 0; k < 10; k++) begin
            rx_drv = frame[k];
            repeat (N) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int base;
        vecs[0] = '{8'h54, 10'h2A8, 8'h54};
        vecs[1] = '{8'h00, 10'h200, 8'h00};
        vecs[2] = '{8'hFF, 10'h3FE, 8'hFF};
        vecs[3] = '{8'hA5, 10'h34A, 8'hA5};

        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        rx_drv   = 1'b1;
        loop_en  = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_tx_line", tx_line, 1'b1);
        check("reset_tx_done", tx_done, 1'b0);
        check("reset_rx_done", rx_done, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_bit_index", dut.rx_bit_index, 3'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 4; i++)
            send_and_check(vecs[i], $sformatf("loop%0d", i));

        // Back-to-back frames with tx_start held high and tx_data changed mid-frame.
        base = rx_seen.size();
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h0F;
        @(negedge clk);
        tx_data  = 8'hC3;
        check_bits(10'h21E, "b2b_first");
        check("b2b_gap1", {tx_done, tx_line}, 2'b11);
        @(negedge clk);
        check("b2b_gap2", {tx_done, tx_line}, 2'b01);
        @(negedge clk);
        tx_start = 1'b0;
        check_bits(10'h386, "b2b_second");
        repeat (10) @(negedge clk);
        check("b2b_rx_count", rx_seen.size() - base, 2);
        if (rx_seen.size() >= 2) begin
            check("b2b_rx_first", rx_seen[$-1], 8'h0F);
            check("b2b_rx_second", rx_seen[$], 8'hC3);
        end

        // Short low glitch on the receive line must be rejected.
        loop_en = 1'b0;
        base = rx_seen.size();
        rx_drv = 1'b0;
        repeat (100) @(negedge clk);
        rx_drv = 1'b1;
        repeat (N) @(negedge clk);
        check("glitch_no_rx_done", rx_seen.size() - base, 0);
        check("glitch_rx_idle", dut.rx_state, IDLE);
        drive_rx_frame(10'h278);
        repeat (10) @(negedge clk);
        check("after_glitch_rx_count", rx_seen.size() - base, 1);
        check("after_glitch_rx_data", rx_data, 8'h3C);

        // Stop bit 0: byte discarded, previous rx_data kept.
        base = rx_seen.size();
        drive_rx_frame(10'h102);
        repeat (N) @(negedge clk);
        check("framing_no_rx_done", rx_seen.size() - base, 0);
        check("framing_rx_data_kept", rx_data, 8'h3C);
        check("framing_rx_idle", dut.rx_state, IDLE);

        // Reset during the data phase of a loopback frame.
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (2 * N + N / 2) @(negedge clk);
        check("pre_reset_line_low", tx_line, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tx_line", tx_line, 1'b1);
        check("midreset_tx_done", tx_done, 1'b0);
        check("midreset_rx_done", rx_done, 1'b0);
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_idle", dut.rx_state, IDLE);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_and_check(vecs[0], "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
